mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RV32I pipeline, directly downstream of `EX`. It takes a latched EX result (command type, effective address, store value, write-back info), performs loads and stores as little-endian byte-serial transactions through the memory arbiter, and stalls the front of the pipeline until each access completes. Non-memory results pass through in zero cycles. It drives the MEM/WB latch and the MEM→ID forwarding path.

## Interface
- Parameters:
- `ADDR_WIDTH`, 32: byte address width; address arithmetic wraps modulo 2^ADDR_WIDTH.
- Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: chip enable; low freezes all state and drops `mem_req_o`.
- `cmdtype_in` in `Cmd_Typebus`: command from EX/MEM latch.
- `rsd_addr_in` in 5, `rsd_data_in` in 32, `write_rsd_in` in 1: EX write-back info.
- `mem_addr_in` in ADDR_WIDTH: effective address.
- `store_val_in` in 32: store data.
- `mem_req_o` out 1, `mem_we_o` out 1, `mem_a_o` out ADDR_WIDTH, `mem_dout_o` out 8: byte request to arbiter.
- `mem_gnt_i` in 1: request accepted this cycle.
- `mem_din_i` in 8: read byte, valid the cycle after a granted read.
- `rsd_addr_o` out 5, `rsd_data_o` out 32, `write_rsd_o` out 1: to MEM/WB.
- `stall_req_o` out 1: hold PC, IF/ID, ID/EX, EX/MEM.
- `mem_forward_id_o` out 1, `mem_forward_addr_o` out 5, `mem_forward_data_o` out 32: forwarding to ID.

## Operation
- States: IDLE, ACCESS, WAIT, DONE. Registers: state, byte index `idx` (2 bits), 32-bit load buffer.
- Byte count n: LB/LBU/SB 1, LH/LHU/SH 2, LW/SW 4.
- IDLE, non-memory cmd: outputs = inputs combinationally, stall 0, stay IDLE.
- IDLE, memory cmd: stall 1, write_rsd_o 0, idx←0, →ACCESS.
- ACCESS: req 1, `mem_a_o` = mem_addr_in+idx, `mem_we_o` = store, `mem_dout_o` = store_val_in[8·idx+7:8·idx] (0 for loads). No grant: hold all request outputs stable, stay. Grant, store: idx==n−1 →DONE else idx++. Grant, load: →WAIT.
- WAIT: req 0; buffer byte idx ← mem_din_i; idx==n−1 →DONE else idx++, →ACCESS.
- DONE: stall 0, req 0. Load: write_rsd_o 1, rsd_addr_o = rsd_addr_in, rsd_data_o = buffer sign-extended (LB/LH) or zero-extended (LBU/LHU/LW). Store: write_rsd_o 0. →IDLE unconditionally.
- Forwarding: `mem_forward_id_o` = write_rsd_o; addr/data mirror rsd_addr_o/rsd_data_o; all 0 while stalled.
- `rdy_in` low: no state change, req 0, other outputs held.
- Reset (any state, mid-transaction included): →IDLE, idx 0, buffer 0, no further request. While `rst_in` low every output is 0.

## Timing
- Latency, grant every request, IDLE=t0: SB DONE t2; SH t3; SW t5; LB/LBU t3; LH/LHU t5; LW t9.
- Each denied grant cycle adds one cycle.
- Load byte captured exactly one cycle after its grant; never two reads outstanding.
- Non-memory instructions: 0 cycles, no stall.
- Stall falls in DONE; next instruction appears in IDLE the following cycle.

## Structure
- Shared package/`define.v`: `Cmd_Typebus`, all `Cmd*` codes, `RegBus`, `RegAddrBus`; add byte-count helper (cmd → n) and is-load/is-store helpers there.
- State encoding local to the module. Single module; no sub-module needed.

## Test plan
- ADDI x5 result 0x12 in IDLE -> same cycle write_rsd_o 1, rsd_data_o 0x12, forward addr 5, stall 0, no req.
- LW addr 0x100, memory bytes 0x78,0x56,0x34,0x12, always grant -> reqs at 0x100..0x103 on t1,t3,t5,t7; t9 rsd_data_o 0x12345678, stall low only at t9.
- LB vs LBU at byte 0x80 -> 0xFFFFFF80 vs 0x00000080; LH bytes 0x00,0x80 -> 0xFFFF8000.
- SW 0xDEADBEEF addr 0x200, grant denied t1–t2 -> request held stable; bytes EF,BE,AD,DE at 0x200..0x203; DONE t7, write_rsd_o 0.
- SH at 0xFFFFFFFF -> second byte address wraps to 0x00000000.
- LW with rst_in low at t4, `rdy_in` low for 2 cycles in another LW -> reset: all outputs 0, IDLE, no req; rdy pause: latency +2, same data.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared pipeline types, command codes and memory-command helpers for the
// RV32I core. The MEM stage uses them to size and shape byte-serial accesses.
package mem_stage_pkg;

   typedef logic [31:0] RegBus;
   typedef logic [4:0]  RegAddrBus;
   typedef logic [4:0]  Cmd_Typebus;

   localparam Cmd_Typebus CmdNOP    = 5'd0;
   localparam Cmd_Typebus CmdALU    = 5'd1;
   localparam Cmd_Typebus CmdLUI    = 5'd2;
   localparam Cmd_Typebus CmdAUIPC  = 5'd3;
   localparam Cmd_Typebus CmdJAL    = 5'd4;
   localparam Cmd_Typebus CmdJALR   = 5'd5;
   localparam Cmd_Typebus CmdBRANCH = 5'd6;
   localparam Cmd_Typebus CmdLB     = 5'd8;
   localparam Cmd_Typebus CmdLH     = 5'd9;
   localparam Cmd_Typebus CmdLW     = 5'd10;
   localparam Cmd_Typebus CmdLBU    = 5'd11;
   localparam Cmd_Typebus CmdLHU    = 5'd12;
   localparam Cmd_Typebus CmdSB     = 5'd13;
   localparam Cmd_Typebus CmdSH     = 5'd14;
   localparam Cmd_Typebus CmdSW     = 5'd15;

   function automatic logic is_load(input Cmd_Typebus cmd);
      return (cmd == CmdLB) || (cmd == CmdLH) || (cmd == CmdLW) ||
             (cmd == CmdLBU) || (cmd == CmdLHU);
   endfunction

   function automatic logic is_store(input Cmd_Typebus cmd);
      return (cmd == CmdSB) || (cmd == CmdSH) || (cmd == CmdSW);
   endfunction

   function automatic logic is_mem(input Cmd_Typebus cmd);
      return is_load(cmd) || is_store(cmd);
   endfunction

   // Number of bytes moved by a memory command (0 for anything else).
   function automatic logic [2:0] byte_count(input Cmd_Typebus cmd);
      case (cmd)
         CmdLB, CmdLBU, CmdSB: return 3'd1;
         CmdLH, CmdLHU, CmdSH: return 3'd2;
         CmdLW, CmdSW:         return 3'd4;
         default:              return 3'd0;
      endcase
   endfunction

   // Sign- or zero-extend an assembled little-endian load value.
   function automatic RegBus load_extend(input Cmd_Typebus cmd, input RegBus raw);
      case (cmd)
         CmdLB:   return {{24{raw[7]}}, raw[7:0]};
         CmdLH:   return {{16{raw[15]}}, raw[15:0]};
         CmdLBU:  return {24'd0, raw[7:0]};
         CmdLHU:  return {16'd0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide request bus between the MEM stage (master) and the memory arbiter (slave).
interface mem_stage_if #(parameter int ADDR_WIDTH = 32);

   logic                  mem_req_o;
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_a_o;
   logic [7:0]            mem_dout_o;
   logic                  mem_gnt_i;
   logic [7:0]            mem_din_i;

   modport master (
      output mem_req_o, mem_we_o, mem_a_o, mem_dout_o,
      input  mem_gnt_i, mem_din_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_a_o, mem_dout_o,
      output mem_gnt_i, mem_din_i
   );

endinterface

// File: rtl/mem_stage.sv
// MEM stage of the five-stage RV32I pipeline: performs loads and stores as
// little-endian byte-serial transactions, stalls the front end while busy and
// passes non-memory results straight through to MEM/WB and the ID forward path.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  Cmd_Typebus            cmdtype_in,
   input  RegAddrBus             rsd_addr_in,
   input  RegBus                 rsd_data_in,
   input  logic                  write_rsd_in,
   input  logic [ADDR_WIDTH-1:0] mem_addr_in,
   input  RegBus                 store_val_in,
   mem_stage_if.master           mem_bus,
   output RegAddrBus             rsd_addr_o,
   output RegBus                 rsd_data_o,
   output logic                  write_rsd_o,
   output logic                  stall_req_o,
   output logic                  mem_forward_id_o,
   output RegAddrBus             mem_forward_addr_o,
   output RegBus                 mem_forward_data_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t   state;
   logic [1:0] idx;
   RegBus    load_buf;

   logic [2:0] n_bytes;
   logic [1:0] last_idx;
   logic       cmd_store;
   logic       cmd_load;
   logic [7:0] store_byte;

   assign n_bytes    = byte_count(cmdtype_in);
   assign last_idx   = 2'(n_bytes - 3'd1);
   assign cmd_store  = is_store(cmdtype_in);
   assign cmd_load   = is_load(cmdtype_in);
   assign store_byte = store_val_in[{idx, 3'b000} +: 8];

   // Walk through the bytes of one access, capturing read data the cycle after each grant.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= IDLE;
         idx      <= 2'd0;
         load_buf <= '0;
      end else if (rdy_in) begin
         case (state)
            IDLE: begin
               if (is_mem(cmdtype_in)) begin
                  idx      <= 2'd0;
                  load_buf <= '0;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (mem_bus.mem_gnt_i) begin
                  if (cmd_store) begin
                     if (idx == last_idx) state <= DONE;
                     else                 idx   <= idx + 2'd1;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               load_buf[{idx, 3'b000} +: 8] <= mem_bus.mem_din_i;
               if (idx == last_idx) begin
                  state <= DONE;
               end else begin
                  idx   <= idx + 2'd1;
                  state <= ACCESS;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   logic                  req_c;
   logic                  we_c;
   logic [ADDR_WIDTH-1:0] addr_c;
   logic [7:0]            dout_c;
   logic                  stall_c;
   logic                  wb_write_c;
   RegAddrBus             wb_addr_c;
   RegBus                 wb_data_c;

   // Decode bus requests, stall and write-back from the state; everything is forced to 0 in reset.
   always_comb begin
      req_c      = 1'b0;
      we_c       = 1'b0;
      addr_c     = '0;
      dout_c     = 8'd0;
      stall_c    = 1'b0;
      wb_write_c = 1'b0;
      wb_addr_c  = '0;
      wb_data_c  = '0;
      if (rst_in) begin
         case (state)
            IDLE: begin
               if (is_mem(cmdtype_in)) begin
                  stall_c = 1'b1;
               end else begin
                  wb_write_c = write_rsd_in;
                  wb_addr_c  = rsd_addr_in;
                  wb_data_c  = rsd_data_in;
               end
            end
            ACCESS: begin
               stall_c = 1'b1;
               req_c   = rdy_in;
               we_c    = cmd_store;
               addr_c  = mem_addr_in + ADDR_WIDTH'(idx);
               dout_c  = cmd_store ? store_byte : 8'd0;
            end
            WAIT: stall_c = 1'b1;
            DONE: begin
               if (cmd_load) begin
                  wb_write_c = 1'b1;
                  wb_addr_c  = rsd_addr_in;
                  wb_data_c  = load_extend(cmdtype_in, load_buf);
               end
            end
            default: stall_c = 1'b0;
         endcase
      end
   end

   assign mem_bus.mem_req_o  = req_c;
   assign mem_bus.mem_we_o   = we_c;
   assign mem_bus.mem_a_o    = addr_c;
   assign mem_bus.mem_dout_o = dout_c;

   assign stall_req_o = stall_c;
   assign write_rsd_o = wb_write_c;
   assign rsd_addr_o  = wb_addr_c;
   assign rsd_data_o  = wb_data_c;

   assign mem_forward_id_o   = wb_write_c & ~stall_c;
   assign mem_forward_addr_o = stall_c ? '0 : wb_addr_c;
   assign mem_forward_data_o = stall_c ? '0 : wb_data_c;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: acts as the memory arbiter, randomizes
// grants and chip-enable pauses, and checks results against a byte-array memory model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   Cmd_Typebus  cmdtype_in;
   logic [4:0]  rsd_addr_in;
   logic [31:0] rsd_data_in;
   logic        write_rsd_in;
   logic [31:0] mem_addr_in;
   logic [31:0] store_val_in;
   logic [4:0]  rsd_addr_o;
   logic [31:0] rsd_data_o;
   logic        write_rsd_o;
   logic        stall_req_o;
   logic        mem_forward_id_o;
   logic [4:0]  mem_forward_addr_o;
   logic [31:0] mem_forward_data_o;

   mem_stage_if #(.ADDR_WIDTH(32)) bus ();

   mem_stage #(.ADDR_WIDTH(32)) dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .rdy_in             (rdy_in),
      .cmdtype_in         (cmdtype_in),
      .rsd_addr_in        (rsd_addr_in),
      .rsd_data_in        (rsd_data_in),
      .write_rsd_in       (write_rsd_in),
      .mem_addr_in        (mem_addr_in),
      .store_val_in       (store_val_in),
      .mem_bus            (bus),
      .rsd_addr_o         (rsd_addr_o),
      .rsd_data_o         (rsd_data_o),
      .write_rsd_o        (write_rsd_o),
      .stall_req_o        (stall_req_o),
      .mem_forward_id_o   (mem_forward_id_o),
      .mem_forward_addr_o (mem_forward_addr_o),
      .mem_forward_data_o (mem_forward_data_o)
   );

   // Free-running 10-unit clock.
   always #5 clk_in = ~clk_in;

   int assertCount = 0;
   int failCount   = 0;
   logic [7:0] memModel [logic [31:0]];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input Cmd_Typebus cmd, input logic [4:0] rd, input logic [31:0] rdata,
                                input logic wr, input logic [31:0] addr, input logic [31:0] sval);
      cmdtype_in   = cmd;
      rsd_addr_in  = rd;
      rsd_data_in  = rdata;
      write_rsd_in = wr;
      mem_addr_in  = addr;
      store_val_in = sval;
   endtask

   function automatic logic [7:0] memRead(input logic [31:0] a);
      if (memModel.exists(a)) return memModel[a];
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic int tbBytes(input Cmd_Typebus c);
      if (c == CmdLB || c == CmdLBU || c == CmdSB) return 1;
      if (c == CmdLH || c == CmdLHU || c == CmdSH) return 2;
      if (c == CmdLW || c == CmdSW) return 4;
      return 0;
   endfunction

   function automatic bit tbIsStore(input Cmd_Typebus c);
      return (c == CmdSB) || (c == CmdSH) || (c == CmdSW);
   endfunction

   // Reference load: assemble little-endian bytes as a number, then wrap negatives for signed loads.
   function automatic logic [31:0] expectedLoad(input Cmd_Typebus cmd, input logic [31:0] addr);
      longint raw = 0;
      int n = tbBytes(cmd);
      for (int i = 0; i < n; i++)
         raw += longint'(memRead(addr + 32'(i))) << (8 * i);
      if ((cmd == CmdLB || cmd == CmdLH) && raw >= (longint'(1) << (8 * n - 1)))
         raw -= longint'(1) << (8 * n);
      return raw[31:0];
   endfunction

   function automatic logic anyOutput();
      return |{bus.mem_req_o, bus.mem_we_o, bus.mem_a_o, bus.mem_dout_o, stall_req_o, write_rsd_o,
               rsd_addr_o, rsd_data_o, mem_forward_id_o, mem_forward_addr_o, mem_forward_data_o};
   endfunction

   // Non-memory instruction: results must appear in the same cycle with no stall and no request.
   task automatic runAluOp(input string tag, input logic [4:0] rd, input logic [31:0] data, input logic wr);
      applyStimulus(CmdALU, rd, data, wr, $urandom, $urandom);
      rdy_in = 1'b1;
      bus.mem_gnt_i = 1'($urandom);
      @(negedge clk_in);
      checkOutput({tag, "/write"}, 32'(write_rsd_o), 32'(wr));
      checkOutput({tag, "/rsdAddr"}, 32'(rsd_addr_o), 32'(rd));
      checkOutput({tag, "/rsdData"}, rsd_data_o, data);
      checkOutput({tag, "/fwd"}, 32'({mem_forward_id_o, mem_forward_addr_o}), 32'({wr, rd}));
      checkOutput({tag, "/fwdData"}, mem_forward_data_o, data);
      checkOutput({tag, "/stallReq"}, 32'({stall_req_o, bus.mem_req_o}), 32'd0);
      @(posedge clk_in); #1;
   endtask

   // One memory instruction issued at t0 and driven to completion (or to abortAt).
   task automatic runMemOp(input string tag, input Cmd_Typebus cmd, input logic [31:0] addr,
                           input logic [31:0] sval, input logic [4:0] rd, input int denyFirst,
                           input int denyPct, input int pauseStart, input int pauseLen,
                           input int abortAt, input bit useConst, input logic [31:0] constVal);
      int n, t, refused, paused, grants, expLat;
      bit store, readPending, held, done, aborted;
      logic [31:0] pendAddr, expAddr, heldA, expData;
      logic [7:0] expDout, heldDout;
      logic heldWe;
      n = tbBytes(cmd);
      store = tbIsStore(cmd);
      expData = store ? 32'd0 : expectedLoad(cmd, addr);
      t = 0; refused = 0; paused = 0; grants = 0;
      readPending = 0; held = 0; done = 0; aborted = 0;
      pendAddr = '0; heldA = '0; heldDout = '0; heldWe = 1'b0;
      applyStimulus(cmd, rd, $urandom, !store, addr, sval);
      while (!done && t < 200) begin
         if (t == abortAt) begin
            aborted = 1;
            break;
         end
         rdy_in = !(t >= pauseStart && t < pauseStart + pauseLen);
         if (!rdy_in) paused++;
         bus.mem_din_i = readPending ? memRead(pendAddr) : 8'($urandom);
         if (rdy_in) readPending = 0;
         bus.mem_gnt_i = 1'b0;
         #1;
         if (bus.mem_req_o)
            bus.mem_gnt_i = !(refused < denyFirst || $urandom_range(0, 99) < denyPct);
         else
            bus.mem_gnt_i = 1'($urandom);
         @(negedge clk_in);
         if (!rdy_in) checkOutput({tag, "/reqWhilePaused"}, 32'(bus.mem_req_o), 32'd0);
         if (bus.mem_req_o) begin
            expAddr = addr + 32'(grants);
            expDout = store ? 8'(sval >> (8 * grants)) : 8'h00;
            checkOutput({tag, "/reqAddr"}, bus.mem_a_o, expAddr);
            checkOutput({tag, "/reqWe"}, 32'(bus.mem_we_o), 32'(store));
            checkOutput({tag, "/reqDout"}, 32'(bus.mem_dout_o), 32'(expDout));
            if (held) checkOutput({tag, "/heldReq"}, {bus.mem_a_o[22:0], bus.mem_we_o, bus.mem_dout_o},
                                  {heldA[22:0], heldWe, heldDout});
            if (bus.mem_gnt_i) begin
               grants++;
               held = 0;
               if (store) memModel[expAddr] = expDout;
               else begin
                  readPending = 1;
                  pendAddr = expAddr;
               end
            end else begin
               refused++;
               held = 1;
               heldA = bus.mem_a_o;
               heldWe = bus.mem_we_o;
               heldDout = bus.mem_dout_o;
            end
         end
         if (!stall_req_o) done = 1;
         else begin
            checkOutput({tag, "/quietWhileStalled"},
                        32'({write_rsd_o, mem_forward_id_o, mem_forward_addr_o}) | mem_forward_data_o, 32'd0);
            @(posedge clk_in); #1;
            t++;
         end
      end
      if (!aborted) begin
         if (!done) checkOutput({tag, "/timeout"}, 32'd0, 32'd1);
         else begin
            expLat = (store ? n + 1 : 2 * n + 1) + refused + paused;
            checkOutput({tag, "/latency"}, 32'(t), 32'(expLat));
            checkOutput({tag, "/grants"}, 32'(grants), 32'(n));
            checkOutput({tag, "/write"}, 32'(write_rsd_o), 32'(!store));
            checkOutput({tag, "/doneReq"}, 32'(bus.mem_req_o), 32'd0);
            if (!store) begin
               checkOutput({tag, "/rsdData"}, rsd_data_o, expData);
               checkOutput({tag, "/rsdAddr"}, 32'(rsd_addr_o), 32'(rd));
               checkOutput({tag, "/fwd"}, 32'({mem_forward_id_o, mem_forward_addr_o}), 32'({1'b1, rd}));
               checkOutput({tag, "/fwdData"}, mem_forward_data_o, expData);
               if (useConst) checkOutput({tag, "/knownValue"}, rsd_data_o, constVal);
            end
         end
         @(posedge clk_in); #1;
      end
      rdy_in = 1'b1;
      bus.mem_gnt_i = 1'b0;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test-plan cases followed by randomized memory instructions.
   initial begin
      Cmd_Typebus memCmds [8];
      memCmds = '{CmdLB, CmdLH, CmdLW, CmdLBU, CmdLHU, CmdSB, CmdSH, CmdSW};
      rst_in = 1'b0;
      rdy_in = 1'b1;
      bus.mem_gnt_i = 1'b0;
      bus.mem_din_i = 8'd0;
      applyStimulus(CmdNOP, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      memModel[32'h100] = 8'h78; memModel[32'h101] = 8'h56;
      memModel[32'h102] = 8'h34; memModel[32'h103] = 8'h12;
      memModel[32'h80]  = 8'h80;
      memModel[32'h90]  = 8'h00; memModel[32'h91]  = 8'h80;

      repeat (2) @(posedge clk_in);
      #1;
      applyStimulus(CmdALU, 5'd7, 32'hCAFEF00D, 1'b1, 32'd0, 32'd0);
      #1;
      checkOutput("resetQuiet", 32'(anyOutput()), 32'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(posedge clk_in); #1;

      runAluOp("addi", 5'd5, 32'h12, 1'b1);
      runAluOp("noWrite", 5'd9, 32'h5555AAAA, 1'b0);
      runMemOp("lw", CmdLW, 32'h100, 32'd0, 5'd10, 0, 0, 99, 0, -1, 1, 32'h12345678);
      runAluOp("afterLw", 5'd11, 32'h0BADF00D, 1'b1);
      runMemOp("lb", CmdLB, 32'h80, 32'd0, 5'd12, 0, 0, 99, 0, -1, 1, 32'hFFFFFF80);
      runMemOp("lbu", CmdLBU, 32'h80, 32'd0, 5'd13, 0, 0, 99, 0, -1, 1, 32'h00000080);
      runMemOp("lh", CmdLH, 32'h90, 32'd0, 5'd14, 0, 0, 99, 0, -1, 1, 32'hFFFF8000);
      runMemOp("sw", CmdSW, 32'h200, 32'hDEADBEEF, 5'd0, 2, 0, 99, 0, -1, 0, 32'd0);
      runMemOp("lwBack", CmdLW, 32'h200, 32'd0, 5'd15, 0, 0, 99, 0, -1, 1, 32'hDEADBEEF);
      runMemOp("shWrap", CmdSH, 32'hFFFFFFFF, 32'h1234A5C3, 5'd0, 0, 0, 99, 0, -1, 0, 32'd0);
      runMemOp("lhuWrap", CmdLHU, 32'hFFFFFFFF, 32'd0, 5'd16, 0, 0, 99, 0, -1, 1, 32'h0000A5C3);

      runMemOp("lwReset", CmdLW, 32'h100, 32'd0, 5'd17, 0, 0, 99, 0, 4, 0, 32'd0);
      #1;
      rst_in = 1'b0;
      applyStimulus(CmdALU, 5'd3, 32'h77777777, 1'b1, 32'h100, 32'd0);
      #1;
      checkOutput("midResetQuiet", 32'(anyOutput()), 32'd0);
      @(posedge clk_in); #1;
      checkOutput("heldResetQuiet", 32'(anyOutput()), 32'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      runAluOp("afterReset", 5'd3, 32'h77777777, 1'b1);
      runMemOp("lwAfterReset", CmdLW, 32'h100, 32'd0, 5'd18, 0, 0, 99, 0, -1, 1, 32'h12345678);
      runMemOp("lwPause", CmdLW, 32'h100, 32'd0, 5'd19, 0, 0, 2, 2, -1, 1, 32'h12345678);

      for (int i = 0; i < 40; i++) begin
         Cmd_Typebus c;
         logic [31:0] a;
         c = memCmds[$urandom_range(0, 7)];
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
         runMemOp("rand", c, a, $urandom, 5'($urandom_range(1, 31)), 0, 25, 1,
                  $urandom_range(0, 2), -1, 0, 32'd0);
         runAluOp("randAlu", 5'($urandom_range(0, 31)), $urandom, 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
